// File: rtl/control_unit.sv
// control_unit: instruction sequencer for the bus datapath.
// Fetches one instruction (pc -> address register, wait MEM_LAT cycles,
// latch din into IR), then steps through up to three execute cycles,
// driving the one-hot bus-source select and the load strobes.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   run            level start request, only looked at in IDLE
//   din            memory data; low IR_W bits become the instruction
//   g_nz           datapath G register is non-zero (mvnz condition)
//   mux_sel[0:9]   bus source: 0=din, 1..7=r0..r6, 8=pc, 9=g
//   r_in[0:6]      load enables for r0..r6
//   pc_in, pc_inc  pc load from bus / pc increment
//   a_in, g_in     A load / G load with alu_sub selecting A-bus
//   addr_in        address register load
//   dout_in, w_d   data-out load and memory write strobe
//   done, busy     last execute cycle pulse / not in IDLE
module control_unit #(
  parameter int unsigned IR_W    = 9,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] din,
  input  logic        g_nz,
  output logic [0:9]  mux_sel,
  output logic [0:6]  r_in,
  output logic        pc_in,
  output logic        pc_inc,
  output logic        a_in,
  output logic        g_in,
  output logic        alu_sub,
  output logic        addr_in,
  output logic        dout_in,
  output logic        w_d,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_F, LOADIR, T1, WAIT_X, T2, T3
  } state_t;

  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_LD, OP_ST, OP_MVNZ, OP_RSVD
  } op_t;

  localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

  state_t          state, state_nx;
  logic [IR_W-1:0] ir;
  logic [1:0]      cnt;
  op_t             op;
  logic [2:0]      rx, ry;
  logic            cnt_last;
  logic            din_unused;

  assign op         = op_t'(ir[8:6]);
  assign rx         = ir[5:3];
  assign ry         = ir[2:0];
  assign cnt_last   = (cnt == LAST);
  assign din_unused = ^din[15:IR_W];

  // Register index 7 is pc: it sources on mux_sel[8] and loads via pc_in.
  function automatic logic [0:9] src_sel(input logic [2:0] r);
    logic [0:9] v;
    v = '0;
    if (r == 3'd7) v[8] = 1'b1;
    else           v[{1'b0, r} + 4'd1] = 1'b1;
    return v;
  endfunction

  function automatic logic [0:6] dst_sel(input logic [2:0] r);
    logic [0:6] v;
    v = '0;
    if (r != 3'd7) v[r] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == LOADIR) ir <= din[IR_W-1:0];
      if ((state == WAIT_F || state == WAIT_X) && !cnt_last) cnt <= cnt + 2'd1;
      else                                                   cnt <= '0;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (run) state_nx = FETCH;
      FETCH:  state_nx = WAIT_F;
      WAIT_F: if (cnt_last) state_nx = LOADIR;
      LOADIR: state_nx = T1;
      T1: begin
        case (op)
          OP_MVI, OP_LD:         state_nx = WAIT_X;
          OP_ADD, OP_SUB, OP_ST: state_nx = T2;
          default:               state_nx = IDLE;
        endcase
      end
      WAIT_X: if (cnt_last) state_nx = T2;
      T2:     state_nx = (op == OP_ADD || op == OP_SUB) ? T3 : IDLE;
      T3:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mux_sel = '0;
    r_in    = '0;
    pc_in   = 1'b0;
    pc_inc  = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    alu_sub = 1'b0;
    addr_in = 1'b0;
    dout_in = 1'b0;
    w_d     = 1'b0;
    done    = 1'b0;
    busy    = (state != IDLE);
    case (state)
      FETCH: begin
        mux_sel[8] = 1'b1;
        addr_in    = 1'b1;
        pc_inc     = 1'b1;
      end
      T1: begin
        case (op)
          OP_MV: begin
            mux_sel = src_sel(ry);
            r_in    = dst_sel(rx);
            pc_in   = (rx == 3'd7);
            done    = 1'b1;
          end
          OP_MVI: begin
            mux_sel[8] = 1'b1;
            addr_in    = 1'b1;
            pc_inc     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            mux_sel = src_sel(rx);
            a_in    = 1'b1;
          end
          OP_LD, OP_ST: begin
            mux_sel = src_sel(ry);
            addr_in = 1'b1;
          end
          OP_MVNZ: begin
            // g_nz is the datapath's registered G flag, so this stays glitch-free.
            if (g_nz) begin
              mux_sel = src_sel(ry);
              r_in    = dst_sel(rx);
              pc_in   = (rx == 3'd7);
            end
            done = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        case (op)
          OP_MVI, OP_LD: begin
            mux_sel[0] = 1'b1;
            r_in       = dst_sel(rx);
            pc_in      = (rx == 3'd7);
            done       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            mux_sel = src_sel(ry);
            g_in    = 1'b1;
            alu_sub = (op == OP_SUB);
          end
          OP_ST: begin
            mux_sel = src_sel(rx);
            dout_in = 1'b1;
            w_d     = 1'b1;
            done    = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        mux_sel[9] = 1'b1;
        r_in       = dst_sel(rx);
        pc_in      = (rx == 3'd7);
        done       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ($onehot0(mux_sel));
      assert (!(pc_in && pc_inc));
    end
  end

endmodule
